// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM state encoding and default bus widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package apb_pkg;

  localparam int unsigned APB_ADDR_W = 8;
  localparam int unsigned APB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

endpackage

// File: rtl/apb_watchdog.sv
// Wait-state watchdog: counts ACCESS cycles with PREADY low and flags the abort cycle.
// Latency: expired_o is combinational on the cycle whose increment would reach TIMEOUT.
// Backpressure: none; clr_i has priority over en_i. TIMEOUT=0 disables the flag.
module apb_watchdog #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  // Value held by the counter during the last stalled cycle that is still tolerated.
  localparam logic [CNT_W-1:0] LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign expired_o = (TIMEOUT != 0) && en_i && (cnt_q == LAST);

  // Next count: clear on a new transfer, otherwise count stalled cycles and hold at expiry.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !expired_o) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/apb_requester.sv
// APB4 initiator: one request at a time through SETUP/ACCESS, with wait states and watchdog abort.
// Latency: rsp_valid one cycle after the completing ACCESS edge; 2 cycles/transfer back-to-back.
// Backpressure: req_ready only in IDLE or ACCESS&&PREADY; rsp_valid is a pulse with no stall.
module apb_requester
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W  = APB_ADDR_W,
  parameter int unsigned DATA_W  = APB_DATA_W,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                PCLK,
  input  logic                PRESET,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_strb,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                PSEL,
  output logic                PENABLE,
  output logic                PWRITE,
  output logic [ADDR_W-1:0]   PADDR,
  output logic [DATA_W-1:0]   PWDATA,
  output logic [DATA_W/8-1:0] PSTRB,
  input  logic [DATA_W-1:0]   PRDATA,
  input  logic                PREADY,
  input  logic                PSLVERR
);

  localparam int unsigned STRB_W = DATA_W / 8;

  apb_state_e          state_q;
  logic                run_q;
  logic                psel_q;
  logic                penable_q;
  logic                pwrite_q;
  logic [ADDR_W-1:0]   paddr_q;
  logic [DATA_W-1:0]   pwdata_q;
  logic [STRB_W-1:0]   pstrb_q;
  logic                rsp_valid_q;
  logic [DATA_W-1:0]   rsp_rdata_q;
  logic                rsp_err_q;

  logic                ready;
  logic                accept;
  logic                wd_en;
  logic                wd_expired;

  // Ready in IDLE or on a completing ACCESS cycle; run_q keeps it low until the first edge after reset.
  always_comb begin
    ready  = run_q && ((state_q == IDLE) || ((state_q == ACCESS) && PREADY));
    accept = ready && req_valid;
    wd_en  = (state_q == ACCESS) && !PREADY;
  end

  apb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk_i     (PCLK),
    .rst_ni    (PRESET),
    .clr_i     (accept),
    .en_i      (wd_en),
    .expired_o (wd_expired)
  );

  // Transfer FSM with registered APB and response outputs.
  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      state_q     <= IDLE;
      run_q       <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      run_q       <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;

      // Capture a newly accepted request; reads keep the old write data and drive no strobes.
      if (accept) begin
        pwrite_q <= req_write;
        paddr_q  <= req_addr;
        if (req_write) begin
          pwdata_q <= req_wdata;
          pstrb_q  <= req_strb;
        end else begin
          pstrb_q  <= '0;
        end
      end

      case (state_q)
        IDLE: begin
          if (accept) begin
            psel_q    <= 1'b1;
            penable_q <= 1'b0;
            state_q   <= SETUP;
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ACCESS;
        end
        ACCESS: begin
          if (PREADY) begin
            // Completion takes priority over a watchdog expiry on the same edge.
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= PSLVERR;
            rsp_rdata_q <= pwrite_q ? '0 : PRDATA;
            penable_q   <= 1'b0;
            if (accept) begin
              psel_q  <= 1'b1;
              state_q <= SETUP;
            end else begin
              psel_q  <= 1'b0;
              state_q <= IDLE;
            end
          end else if (wd_expired) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          psel_q    <= 1'b0;
          penable_q <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign req_ready = ready;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign PSTRB     = pstrb_q;

endmodule

// File: tb/tb_apb_requester.sv
// Bench for apb_requester with a behavioural APB memory slave that can stall, stick or error.
// Responses are predicted at accept time into a queue and checked by a separate monitor.
// Directed cases: strobed writes, reads, back-to-back, wait states, timeout, async reset.
module tb_apb_requester;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        PCLK;
  logic        PRESET;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_strb;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [7:0]  PADDR;
  logic [31:0] PWDATA;
  logic [3:0]  PSTRB;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  int checks = 0;
  int errors = 0;

  exp_t sb[$];

  // slave model controls
  int          wait_cfg = 0;
  logic        stuck    = 1'b0;
  logic        err_cfg  = 1'b0;
  int          waits_q  = 0;
  logic [31:0] mem [256];

  // bus statistics gathered by the monitor
  int          psel_cnt  = 0;
  int          pen_cnt   = 0;
  int          rsp_cnt   = 0;
  int          stab_err  = 0;
  logic [7:0]  pen_hist  = '0;
  logic [3:0]  pstrb_or  = '0;
  logic        prev_psel = 1'b0;
  logic [7:0]  prev_addr = '0;
  logic        prev_write = 1'b0;

  apb_requester #(
    .ADDR_W  (8),
    .DATA_W  (32),
    .TIMEOUT (4)
  ) dut (
    .PCLK      (PCLK),
    .PRESET    (PRESET),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_strb  (req_strb),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PWRITE    (PWRITE),
    .PADDR     (PADDR),
    .PWDATA    (PWDATA),
    .PSTRB     (PSTRB),
    .PRDATA    (PRDATA),
    .PREADY    (PREADY),
    .PSLVERR   (PSLVERR)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // APB memory slave: wait count loaded in SETUP, byte-strobed writes on completion.
  assign PREADY  = PSEL && PENABLE && (waits_q == 0) && !stuck;
  assign PRDATA  = mem[PADDR];
  assign PSLVERR = err_cfg;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
  end

  always @(posedge PCLK) begin
    if (PSEL && !PENABLE) waits_q <= wait_cfg;
    else if (PSEL && PENABLE && waits_q != 0) waits_q <= waits_q - 1;
    if (PSEL && PENABLE && PREADY && PWRITE) begin
      for (int b = 0; b < 4; b++)
        if (PSTRB[b]) mem[PADDR][8*b +: 8] = PWDATA[8*b +: 8];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every response pulse and gathers bus statistics.
  always @(negedge PCLK) begin
    exp_t e;
    if (PRESET && rsp_valid) begin
      rsp_cnt++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected: got rdata %h err %0d expected no response", rsp_rdata, rsp_err);
      end else begin
        e = sb.pop_front();
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
      end
    end
    if (PSEL) begin
      psel_cnt++;
      pen_hist = {pen_hist[6:0], PENABLE};
      pstrb_or = pstrb_or | PSTRB;
    end
    if (PSEL && PENABLE) begin
      pen_cnt++;
      if (prev_psel && (PADDR != prev_addr || PWRITE != prev_write)) stab_err++;
    end
    prev_psel  = PSEL;
    prev_addr  = PADDR;
    prev_write = PWRITE;
  end

  task automatic clear_stats();
    psel_cnt = 0;
    pen_cnt  = 0;
    rsp_cnt  = 0;
    stab_err = 0;
    pen_hist = '0;
    pstrb_or = '0;
  endtask

  // Present a request and return right after the edge that accepts it.
  task automatic issue(input logic w, input logic [7:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic [31:0] er, input logic ee);
    logic done;
    exp_t e;
    done = 1'b0;
    @(negedge PCLK);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    req_strb  = s;
    for (int i = 0; i < 50 && !done; i++) begin
      #1;
      if (req_ready) begin
        e.rdata = er;
        e.err   = ee;
        sb.push_back(e);
        @(posedge PCLK);
        done = 1'b1;
      end else begin
        @(negedge PCLK);
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got req_ready 0 for 50 cycles expected accept at addr %h", a);
    end
  endtask

  task automatic idle();
    @(negedge PCLK);
    req_valid = 1'b0;
  endtask

  task automatic wait_done();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge PCLK);
      #2;
      if (sb.size() == 0 && !PSEL && !rsp_valid) done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL rsp_timeout: got %0d pending responses expected 0", sb.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000");
    $fatal(1, "simulation hung");
  end

  initial begin
    PRESET    = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_strb  = '0;
    repeat (3) @(negedge PCLK);
    #1;
    chk("rst_psel", {31'b0, PSEL}, 32'h0);
    chk("rst_penable", {31'b0, PENABLE}, 32'h0);
    chk("rst_req_ready", {31'b0, req_ready}, 32'h0);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    chk("rst_paddr", {24'b0, PADDR}, 32'h0);
    chk("rst_pstrb", {28'b0, PSTRB}, 32'h0);
    @(negedge PCLK);
    PRESET = 1'b1;

    // 1: zero-wait write
    clear_stats();
    issue(1'b1, 8'h05, 32'h0000ABCD, 4'b0111, 32'h0, 1'b0);
    idle();
    wait_done();
    chk("c1_psel_cycles", psel_cnt, 2);
    chk("c1_penable_cycles", pen_cnt, 1);
    chk("c1_pstrb", {28'b0, pstrb_or}, 32'h7);
    chk("c1_rsp_count", rsp_cnt, 1);

    // 2: read back, partial overwrite of bytes 0-1, read again
    clear_stats();
    issue(1'b0, 8'h05, 32'h0, 4'b1111, 32'h0000ABCD, 1'b0);
    idle();
    wait_done();
    chk("c2_read_pstrb", {28'b0, pstrb_or}, 32'h0);
    issue(1'b1, 8'h05, 32'h55050055, 4'b0011, 32'h0, 1'b0);
    issue(1'b0, 8'h05, 32'h0, 4'b0000, 32'h00000055, 1'b0);
    idle();
    wait_done();

    // 3: back-to-back write then read with req_valid held
    clear_stats();
    issue(1'b1, 8'h0A, 32'h000AAAAA, 4'b1111, 32'h0, 1'b0);
    issue(1'b0, 8'h0A, 32'h0, 4'b0000, 32'h000AAAAA, 1'b0);
    idle();
    wait_done();
    chk("c3_psel_cycles", psel_cnt, 4);
    chk("c3_penable_pattern", {28'b0, pen_hist[3:0]}, 32'h5);
    chk("c3_rsp_count", rsp_cnt, 2);

    // 4: three wait states on a read, slave reports an error
    wait_cfg = 3;
    err_cfg  = 1'b1;
    clear_stats();
    issue(1'b0, 8'h0F, 32'h0, 4'b0000, 32'h0, 1'b1);
    idle();
    wait_done();
    chk("c4_access_cycles", pen_cnt, 4);
    chk("c4_stability", stab_err, 0);
    chk("c4_rsp_count", rsp_cnt, 1);
    wait_cfg = 0;
    err_cfg  = 1'b0;

    // 5: slave never ready -> abort after 4 ACCESS cycles, then normal traffic
    stuck = 1'b1;
    clear_stats();
    issue(1'b0, 8'h05, 32'h0, 4'b0000, 32'h0, 1'b1);
    idle();
    wait_done();
    chk("c5_access_cycles", pen_cnt, 4);
    chk("c5_psel_cycles", psel_cnt, 5);
    stuck = 1'b0;
    issue(1'b1, 8'h20, 32'h12345678, 4'b1111, 32'h0, 1'b0);
    issue(1'b0, 8'h20, 32'h0, 4'b0000, 32'h12345678, 1'b0);
    idle();
    wait_done();

    // 6: asynchronous reset in the middle of ACCESS
    stuck = 1'b1;
    issue(1'b0, 8'h05, 32'h0, 4'b0000, 32'h0, 1'b1);
    idle();
    @(negedge PCLK);
    #3;
    PRESET = 1'b0;
    #1;
    chk("c6_psel", {31'b0, PSEL}, 32'h0);
    chk("c6_penable", {31'b0, PENABLE}, 32'h0);
    chk("c6_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    chk("c6_req_ready", {31'b0, req_ready}, 32'h0);
    sb.delete();
    clear_stats();
    stuck = 1'b0;
    repeat (3) @(negedge PCLK);
    PRESET = 1'b1;
    @(negedge PCLK);
    chk("c6_no_response", rsp_cnt, 0);
    issue(1'b1, 8'hFF, 32'hCAFEF00D, 4'b1111, 32'h0, 1'b0);
    issue(1'b0, 8'hFF, 32'h0, 4'b0000, 32'hCAFEF00D, 1'b0);
    idle();
    wait_done();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
